logic_gate_arbiter: RTL and testbench
=====================================

Name: logic_gate_arbiter

Overview:
- Shares one registered 2-input logic unit (NOR, AND, OR, etc.) among NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on both the request and response sides.
- Sits between simple requester blocks and the gate datapath, so several clients can reuse one gate evaluation resource without contention.
- One operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 1, operand width; the gate is applied bitwise.
- IDW, 2, width of the response requester-ID; must satisfy 2**IDW >= NUM_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  operand a; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  operand b; same slicing as req_a.
- req_op  in  NUM_REQ*3  opcode; requester i occupies slice [i*3 +: 3].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts result.
- rsp_y  out  WIDTH  gate result.
- rsp_id  out  IDW  index of the requester that owns the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Opcodes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT a (b ignored), 7 BUF a.
- Reset (asynchronous, immediate):
  - state=IDLE, rsp_valid=0, rsp_y=0, rsp_id=0, busy=0, req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - A reset mid-operation discards the in-flight operation; no response is issued for it.
- State IDLE:
  - req_ready is combinational: one-hot at the winner when any req_valid is high, otherwise 0.
  - Winner is the first asserted req_valid searching upward from last_grant+1, modulo NUM_REQ.
  - At the clock edge with a winner: capture a, b, op and id; set last_grant=winner; go to EXEC.
  - req_ready is never asserted outside IDLE.
- State EXEC (1 cycle):
  - Compute the result bitwise from the captured operands.
  - Register it into rsp_y, set rsp_valid=1, go to RESP.
- State RESP:
  - rsp_valid, rsp_y and rsp_id are held stable until rsp_ready is high at an edge.
  - On that edge: rsp_valid=0, go to IDLE.
  - The next grant therefore happens no earlier than the cycle after the response handshake.
- Latency:
  - Request accepted at edge N; rsp_valid is high from edge N+2.
  - Minimum issue interval is 3 cycles.
- Fairness: a requester that holds req_valid is granted within NUM_REQ grants.
- Requesters may drop req_valid before acceptance; the arbiter only samples it in IDLE.
- A requester that re-asserts req_valid immediately after its grant gets the lowest priority on the next arbitration.
- An undefined opcode cannot occur (3-bit code is fully decoded); all 8 values are defined.
- Width rules: every operation is bitwise over WIDTH; there are no carries and no width growth.

Decomposition:
- Package logic_gate_pkg holds:
  - opcode localparams OP_AND..OP_BUF (3-bit);
  - state encoding IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module rr_arbiter (purely combinational):
  - inputs: req[NUM_REQ], last_grant;
  - outputs: one-hot grant, grant index, any_grant.
- The logic-unit case statement stays inline in the top module.

Test Plan:
- Single NOR: reset, then req_valid=4'b0001, a=1, b=0, op=3 → req_ready[0]=1 in the same cycle; rsp_valid at acceptance+2 with rsp_y=0, rsp_id=0. Then a=0, b=0 → rsp_y=1.
- Truth-table sweep: requester 2 issues all 8 ops × 4 operand pairs (WIDTH=1) → every rsp_y matches the golden model and rsp_id=2.
- Round-robin: all four req_valid held high → grant order 0,1,2,3,0,1; no requester is granted twice before the others are served.
- Back-pressure: hold rsp_ready=0 for 5 cycles while in RESP → rsp_valid, rsp_y and rsp_id stay stable; req_ready stays 0 for every requester despite requests.
- Async reset mid-EXEC: assert rst between edges → rsp_valid=0 and busy=0 immediately. After release with req_valid=4'b1010, requester 1 is granted first.
- Bitwise width: instance with WIDTH=4, a=4'b1100, b=4'b1010, op=XOR → rsp_y=4'b0110; op=NOR → rsp_y=4'b0001.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared opcode and FSM state definitions for the logic-gate arbiter.
package logic_gate_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_gate_arbiter_if.sv
// Request/response bundle between the requester blocks and the shared gate unit.
interface logic_gate_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 1,
    parameter int IDW     = 2
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a requester may withdraw valid at any time before that edge, the arbiter holds rsp_* until taken.
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ*3-1:0]     req_op;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [WIDTH-1:0]         rsp_y;
    logic [IDW-1:0]           rsp_id;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request above last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_grant
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        // last_grant itself is visited last, giving it the lowest priority
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = IDW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/logic_gate_arbiter.sv
// Round-robin shared 2-input bitwise logic unit, one operation in flight at a time.
module logic_gate_arbiter
    import logic_gate_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 1,
    parameter int IDW     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_gate_arbiter_if.slave  bus,
    output logic                 busy,
    output state_t               state
);

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               any_grant;
    logic [IDW-1:0]     last_grant;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   gate_y;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    assign bus.req_ready = (state == IDLE) ? grant : '0;
    assign busy          = (state != IDLE);

    always_comb begin
        gate_y = '0;
        case (op_q)
            OP_AND:  gate_y = a_q & b_q;
            OP_OR:   gate_y = a_q | b_q;
            OP_NAND: gate_y = ~(a_q & b_q);
            OP_NOR:  gate_y = ~(a_q | b_q);
            OP_XOR:  gate_y = a_q ^ b_q;
            OP_XNOR: gate_y = ~(a_q ^ b_q);
            OP_NOT:  gate_y = ~a_q;
            OP_BUF:  gate_y = a_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_id    <= '0;
            last_grant    <= IDW'(NUM_REQ - 1);
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= OP_AND;
        end else begin
            case (state)
                IDLE: begin
                    // rsp_valid is low here, so rsp_id can take the new owner directly
                    if (any_grant) begin
                        a_q        <= bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        b_q        <= bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        op_q       <= bus.req_op[int'(grant_idx)*3 +: 3];
                        bus.rsp_id <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_y     <= gate_y;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Randomized bench for logic_gate_arbiter against a truth-table / round-robin reference model.
module tb_logic_gate_arbiter;
    import logic_gate_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 1;
    localparam int IDW     = 2;
    localparam int W       = IDW + WIDTH;
    localparam int AW      = NUM_REQ * WIDTH;
    localparam int OW      = NUM_REQ * 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic_gate_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();
    logic_gate_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(4), .IDW(IDW))     bus_w ();

    logic   busy, busy_w;
    state_t state, state_w;

    logic_gate_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .IDW(IDW)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .state (state)
    );

    logic_gate_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(4), .IDW(IDW)) u_dut_w (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_w),
        .busy  (busy_w),
        .state (state_w)
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];
    int model_last = NUM_REQ - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each op is a 4-entry truth table indexed by {a,b}, applied per bit.
    function automatic logic [3:0] golden(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] tt;
        logic [3:0] y;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 4; i++) y[i] = tt[{a[i], b[i]}];
        return y;
    endfunction

    function automatic int model_winner(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++)
            if (v[(model_last + k) % NUM_REQ]) return (model_last + k) % NUM_REQ;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic rand_ops();
        bus.req_a  = AW'($urandom);
        bus.req_b  = AW'($urandom);
        bus.req_op = OW'($urandom);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the acceptance edge.
    task automatic accept(input logic [NUM_REQ-1:0] vld, input bit drop);
        int w;
        logic [NUM_REQ-1:0] oh;
        logic [3:0] g;
        bus.req_valid = vld;
        #1;
        w  = model_winner(vld);
        oh = (w >= 0) ? (NUM_REQ'(1) << w) : '0;
        check("req_ready_idle", bus.req_ready, oh);
        if (w >= 0) begin
            g = golden(bus.req_op[w*3 +: 3], {3'b0, bus.req_a[w]}, {3'b0, bus.req_b[w]});
            exp_q.push_back({IDW'(w), g[0]});
            model_last = w;
        end
        @(posedge clk);
        #1;
        if (drop) bus.req_valid = '0;
        check("busy_exec", busy, w >= 0);
        check("req_ready_exec", bus.req_ready, 0);
        check("rsp_valid_exec", bus.rsp_valid, 0);
    endtask

    task automatic respond(input int stall);
        logic [W-1:0] e;
        logic [NUM_REQ-1:0] saved;
        saved = bus.req_valid;
        @(posedge clk);
        #1;
        check("rsp_valid_lat", bus.rsp_valid, 1);
        check("sb_size", exp_q.size(), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("rsp_y", bus.rsp_y, e[WIDTH-1:0]);
        check("rsp_id", bus.rsp_id, e[W-1:WIDTH]);
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
            @(posedge clk);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_y", bus.rsp_y, e[WIDTH-1:0]);
            check("hold_id", bus.rsp_id, e[W-1:WIDTH]);
            check("hold_ready", bus.req_ready, 0);
            check("hold_busy", busy, 1);
        end
        bus.req_valid = saved;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_done", bus.rsp_valid, 0);
        check("busy_done", busy, 0);
    endtask

    task automatic width_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bus_w.req_a     = {12'b0, a};
        bus_w.req_b     = {12'b0, b};
        bus_w.req_op    = {9'b0, op};
        bus_w.req_valid = 4'b0001;
        #1;
        check("w_ready", bus_w.req_ready, 4'b0001);
        @(posedge clk);
        #1;
        bus_w.req_valid = '0;
        @(posedge clk);
        #1;
        check("w_valid", bus_w.rsp_valid, 1);
        check("w_y", bus_w.rsp_y, golden(op, a, b));
        check("w_id", bus_w.rsp_id, 0);
        bus_w.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_w.rsp_ready = 1'b0;
        check("w_done", bus_w.rsp_valid, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        model_last = NUM_REQ - 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    int rr_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst             = 1'b1;
        bus.req_valid   = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_op      = '0;
        bus.rsp_ready   = 1'b0;
        bus_w.req_valid = '0;
        bus_w.req_a     = '0;
        bus_w.req_b     = '0;
        bus_w.req_op    = '0;
        bus_w.rsp_ready = 1'b0;
        #3;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_y", bus.rsp_y, 0);
        check("rst_rsp_id", bus.rsp_id, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        do_reset();

        // round-robin with every requester holding valid
        rand_ops();
        for (int k = 0; k < 6; k++) begin
            bus.req_valid = 4'b1111;
            #1;
            check("rr_order", bus.req_ready, 4'b0001 << rr_order[k]);
            accept(4'b1111, 1'b0);
            respond(0);
        end
        bus.req_valid = '0;

        // single NOR on requester 0
        bus.req_a = 4'b0001; bus.req_b = 4'b0000; bus.req_op = 12'd3;
        accept(4'b0001, 1'b1);
        respond(0);
        bus.req_a = 4'b0000;
        accept(4'b0001, 1'b1);
        respond(0);

        // truth-table sweep from requester 2
        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < 4; p++) begin
                bus.req_op[6 +: 3] = 3'(op);
                bus.req_a[2]       = p[1];
                bus.req_b[2]       = p[0];
                accept(4'b0100, 1'b1);
                respond(0);
            end
        end

        // back-pressure
        rand_ops();
        accept(4'b0110, 1'b1);
        respond(5);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            accept(NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1)), 1'($urandom_range(0, 1)));
            respond($urandom_range(0, 3));
        end
        bus.req_valid = '0;

        // asynchronous reset in EXEC, then requester 1 first
        rand_ops();
        accept(4'b1000, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_exec_busy", busy, 0);
        check("arst_exec_valid", bus.rsp_valid, 0);
        do_reset();
        rand_ops();
        accept(4'b1010, 1'b1);
        respond(0);

        // asynchronous reset in RESP drops the response at once
        rand_ops();
        accept(4'b0100, 1'b1);
        @(posedge clk);
        #1;
        check("resp_valid_pre", bus.rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_resp_valid", bus.rsp_valid, 0);
        check("arst_resp_y", bus.rsp_y, 0);
        check("arst_resp_busy", busy, 0);
        do_reset();

        // WIDTH=4 instance
        width_op(OP_XOR, 4'b1100, 4'b1010);
        check("w_xor_const", bus_w.rsp_y, 4'b0110);
        width_op(OP_NOR, 4'b1100, 4'b1010);
        check("w_nor_const", bus_w.rsp_y, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
